// File: rtl/uart_cmd_pkg.sv
// Shared state encoding, error codes and default header byte for the UART command path.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_WRITE
    } cmd_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_OVR  = 2'd3;

    localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout: down-counter loaded with TICKS on clear, decremented per tick while enabled.
// expired flags the tick that exhausts the budget (or an already exhausted budget); shared with the TX side.
module uart_frame_timer #(
    parameter int TICKS = 320
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = $clog2(TICKS + 1);

    logic [CNT_W-1:0] remaining;

    // Clear beats tick, so a strobe coinciding with the final tick restarts the budget.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            remaining <= CNT_W'(TICKS);
        end else if (en && tick && (remaining != '0)) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign expired = en && ((remaining == '0) || (tick && (remaining == CNT_W'(1))));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames UART rx bytes (HDR, ADDR, DATA[, CHK]) into single-beat register writes.
// Build option CMD_CHECKSUM_EN adds the CHK byte and its comparator.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | hunting for HDR_BYTE, other bytes discarded silently
// ST_ADDR  | waiting for address byte, range-checked against ADDR_W
// ST_DATA  | waiting for data byte
// ST_CHK   | waiting for checksum byte (ADDR ^ DATA), checksum builds only
// ST_WRITE | o_wr_en held until i_wr_ready, stray bytes flagged as overrun
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE      = DEFAULT_HDR_BYTE,
    parameter int         ADDR_W        = 4,
    parameter int         TIMEOUT_TICKS = 320
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              b_tick,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_done,
    output logic              o_wr_en,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic              o_busy
);

    cmd_state_t state;
    logic       in_frame;
    logic       tmo_clear;
    logic       tmo_expired;

    assign in_frame  = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CHK);
    assign tmo_clear = (state == ST_IDLE) || (in_frame && i_rx_done);

    uart_frame_timer #(
        .TICKS (TIMEOUT_TICKS)
    ) u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .en      (in_frame),
        .tick    (b_tick),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_err      <= 1'b0;
            o_err_code <= ERR_NONE;
            o_busy     <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_rx_done && (i_rx_data == HDR_BYTE)) begin
                        state  <= ST_ADDR;
                        o_busy <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (i_rx_done) begin
                        if ((i_rx_data >> ADDR_W) != 8'd0) begin
                            o_err      <= 1'b1;
                            o_err_code <= ERR_OVR;
                            state      <= ST_IDLE;
                            o_busy     <= 1'b0;
                        end else begin
                            o_wr_addr <= i_rx_data[ADDR_W-1:0];
                            state     <= ST_DATA;
                        end
                    end else if (tmo_expired) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_TMO;
                        state      <= ST_IDLE;
                        o_busy     <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (i_rx_done) begin
                        o_wr_data <= i_rx_data;
`ifdef CMD_CHECKSUM_EN
                        state     <= ST_CHK;
`else
                        state     <= ST_WRITE;
                        o_wr_en   <= 1'b1;
`endif
                    end else if (tmo_expired) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_TMO;
                        state      <= ST_IDLE;
                        o_busy     <= 1'b0;
                    end
                end
`ifdef CMD_CHECKSUM_EN
                ST_CHK: begin
                    if (i_rx_done) begin
                        if (i_rx_data == (8'(o_wr_addr) ^ o_wr_data)) begin
                            state   <= ST_WRITE;
                            o_wr_en <= 1'b1;
                        end else begin
                            o_err      <= 1'b1;
                            o_err_code <= ERR_CHK;
                            state      <= ST_IDLE;
                            o_busy     <= 1'b0;
                        end
                    end else if (tmo_expired) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_TMO;
                        state      <= ST_IDLE;
                        o_busy     <= 1'b0;
                    end
                end
`endif
                ST_WRITE: begin
                    // A byte landing here is dropped; the pending write is unaffected.
                    if (i_rx_done) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_OVR;
                    end
                    if (i_wr_ready) begin
                        o_wr_en <= 1'b0;
                        state   <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_wr_en <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus random frames
// checked against per-frame outcomes computed from the framing rules.
module tb_uart_cmd_ctrl;

    localparam int         ADDR_W = 4;
    localparam int         TMO    = 320;
    localparam logic [7:0] HDR    = 8'hA5;

    logic              clk = 1'b0;
    logic              rst;
    logic              b_tick;
    logic [7:0]        i_rx_data;
    logic              i_rx_done;
    logic              o_wr_en;
    logic              i_wr_ready;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [7:0]        o_wr_data;
    logic              o_err;
    logic [1:0]        o_err_code;
    logic              o_busy;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         div = 0;
    bit         tick_seen = 1'b0;
    logic [1:0] last_code = 2'd0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .HDR_BYTE      (HDR),
        .ADDR_W        (ADDR_W),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .b_tick     (b_tick),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .o_wr_en    (o_wr_en),
        .i_wr_ready (i_wr_ready),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_err      (o_err),
        .o_err_code (o_err_code),
        .o_busy     (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: b_tick every 4th cycle, then sample 1 time unit after the edge.
    task automatic cyc();
        b_tick    = (div == 3);
        tick_seen = b_tick;
        div       = (div + 1) % 4;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        cyc();
        i_rx_done = 1'b0;
    endtask

    task automatic gap(input int max_cycles);
        int n = $urandom_range(0, max_cycles);
        for (int k = 0; k < n; k++) begin
            i_wr_ready = 1'($urandom_range(0, 1));
            cyc();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_en"}, o_wr_en, 0);
        check({tag, "_addr"}, o_wr_addr, 0);
        check({tag, "_data"}, o_wr_data, 0);
        check({tag, "_err"}, o_err, 0);
        check({tag, "_code"}, o_err_code, 0);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    // Sends HDR,a,d[,c] and checks the outcome the framing rules predict.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                             input int gap_max, input int wait_cycles);
        bit range_bad = ((a >> ADDR_W) != 0);
        bit chk_bad   = 1'b0;
`ifdef CMD_CHECKSUM_EN
        chk_bad = (c != (a ^ d));
`endif
        send_byte(HDR);
        check("hdr_busy", o_busy, 1);
        check("hdr_err", o_err, 0);
        gap(gap_max);
        send_byte(a);
        if (range_bad) begin
            check("range_err", o_err, 1);
            check("range_code", o_err_code, 3);
            check("range_busy", o_busy, 0);
            check("range_wr_en", o_wr_en, 0);
            last_code = 2'd3;
            return;
        end
        check("addr_err", o_err, 0);
        gap(gap_max);
        send_byte(d);
`ifdef CMD_CHECKSUM_EN
        check("data_err", o_err, 0);
        check("data_wr_en", o_wr_en, 0);
        gap(gap_max);
        send_byte(c);
`endif
        if (chk_bad) begin
            check("chk_err", o_err, 1);
            check("chk_code", o_err_code, 1);
            check("chk_busy", o_busy, 0);
            check("chk_wr_en", o_wr_en, 0);
            last_code = 2'd1;
            return;
        end
        check("wr_en_rise", o_wr_en, 1);
        check("wr_addr", o_wr_addr, a[ADDR_W-1:0]);
        check("wr_data", o_wr_data, d);
        check("wr_no_err", o_err, 0);
        check("code_held", o_err_code, last_code);
        for (int k = 0; k < wait_cycles; k++) begin
            i_wr_ready = 1'b0;
            cyc();
            check("bp_wr_en", o_wr_en, 1);
            check("bp_addr", o_wr_addr, a[ADDR_W-1:0]);
            check("bp_data", o_wr_data, d);
        end
        i_wr_ready = 1'b1;
        cyc();
        check("xfer_wr_en", o_wr_en, 0);
        check("xfer_busy", o_busy, 0);
    endtask

    // HDR,03 then silence; optionally land the data byte on the exhausting tick.
    task automatic timeout_test(input bit strobe_at_limit);
        int n = 0;
        int early = 0;
        send_byte(HDR);
        send_byte(8'h03);
        i_wr_ready = 1'b0;
        while (n < TMO - 1) begin
            cyc();
            if (tick_seen) n++;
            if (o_err) early++;
        end
        check("tmo_early", early, 0);
        if (!strobe_at_limit) begin
            for (int k = 0; k < 4; k++) begin
                cyc();
                if (tick_seen) break;
            end
            check("tmo_err", o_err, 1);
            check("tmo_code", o_err_code, 2);
            check("tmo_busy", o_busy, 0);
            last_code = 2'd2;
        end else begin
            while (div != 3) cyc();
            send_byte(8'h5C);
            check("edge_no_err", o_err, 0);
            check("edge_busy", o_busy, 1);
`ifdef CMD_CHECKSUM_EN
            send_byte(8'h5F);
`endif
            check("edge_wr_en", o_wr_en, 1);
            check("edge_data", o_wr_data, 8'h5C);
            i_wr_ready = 1'b1;
            cyc();
            check("edge_xfer", o_wr_en, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a, d, c, j;
        rst        = 1'b1;
        b_tick     = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_done  = 1'b0;
        i_wr_ready = 1'b0;
        repeat (3) cyc();
        check_reset_vals("reset");
        rst = 1'b0;
        cyc();

        run_frame(8'h03, 8'h5C, 8'h5F, 0, 0);
`ifdef CMD_CHECKSUM_EN
        run_frame(8'h03, 8'h5C, 8'h00, 0, 0);
`endif
        send_byte(8'h11);
        check("junk1_err", o_err, 0);
        send_byte(8'h22);
        check("junk2_busy", o_busy, 0);
        run_frame(8'h13, 8'h00, 8'h00, 0, 0);
        run_frame(8'h05, HDR, 8'h05 ^ HDR, 1, 0);
        run_frame(8'h07, 8'h99, 8'h9E, 0, 0);

        timeout_test(1'b0);
        run_frame(8'h03, 8'h5C, 8'h5F, 2, 0);
        timeout_test(1'b1);

        // Backpressure with a stray byte mid-wait.
        i_wr_ready = 1'b0;
        send_byte(HDR);
        send_byte(8'h03);
        send_byte(8'h5C);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h5F);
`endif
        check("bpx_wr_en", o_wr_en, 1);
        cyc();
        send_byte(8'h77);
        check("ovr_err", o_err, 1);
        check("ovr_code", o_err_code, 3);
        check("ovr_wr_en", o_wr_en, 1);
        check("ovr_addr", o_wr_addr, 3);
        check("ovr_data", o_wr_data, 8'h5C);
        last_code = 2'd3;
        repeat (2) cyc();
        check("ovr_pulse", o_err, 0);
        i_wr_ready = 1'b1;
        cyc();
        check("ovr_xfer", o_wr_en, 0);
        run_frame(8'h0A, 8'h3C, 8'h36, 0, 0);

        // Reset mid-frame and mid-write.
        send_byte(HDR);
        send_byte(8'h03);
        rst = 1'b1;
        cyc();
        check_reset_vals("rst_frame");
        rst = 1'b0;
        last_code = 2'd0;
        i_wr_ready = 1'b0;
        send_byte(HDR);
        send_byte(8'h02);
        send_byte(8'h33);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h31);
`endif
        check("rstw_wr_en", o_wr_en, 1);
        rst = 1'b1;
        cyc();
        check_reset_vals("rst_write");
        rst = 1'b0;
        i_wr_ready = 1'b1;
        repeat (3) begin
            cyc();
            check("rstw_abandon", o_wr_en, 0);
        end

        for (int f = 0; f < 60; f++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                j = 8'($urandom);
                if (j == HDR) j = 8'h00;
                send_byte(j);
                check("rnd_junk_busy", o_busy, 0);
            end
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            d = 8'($urandom);
            c = a ^ d;
`ifdef CMD_CHECKSUM_EN
            if ($urandom_range(0, 4) == 0) c = c ^ (8'h01 << $urandom_range(0, 7));
`endif
            run_frame(a, d, c, 3, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
